// File: rtl/ham_pkg.sv
// ============================================================================
// Module      : ham_pkg
// Description : Shared types, constants and the (15,11) Hamming encoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ham_pkg;

    typedef logic [11:1] ham_data_t;
    typedef logic [15:1] ham_code_t;

    localparam int P1_POS = 1;
    localparam int P2_POS = 2;
    localparam int P4_POS = 4;
    localparam int P8_POS = 8;

    localparam logic [3:0] CNT_FIRST = 4'd1;
    localparam logic [3:0] CNT_LAST  = 4'd15;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } ham_state_t;

    // Data bits fill the non-power-of-two positions in ascending order.
    function automatic ham_code_t ham_encode(input ham_data_t d);
        ham_code_t c;
        c = {d[11:5], 1'b0, d[4:2], 1'b0, d[1], 2'b00};
        c[P1_POS] = d[1] ^ d[2] ^ d[4] ^ d[5] ^ d[7] ^ d[9]  ^ d[11];
        c[P2_POS] = d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[7] ^ d[10] ^ d[11];
        c[P4_POS] = d[2] ^ d[3] ^ d[4] ^ d[8] ^ d[9] ^ d[10] ^ d[11];
        c[P8_POS] = d[5] ^ d[6] ^ d[7] ^ d[8] ^ d[9] ^ d[10] ^ d[11];
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ham_tx_if.sv
// ============================================================================
// Module      : ham_tx_if
// Description : Data handshake and serial output bundle of the Hamming TX.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ham_tx_if;
    import ham_pkg::*;

    ham_data_t data_in;
    logic      data_valid;
    logic      data_ready;
    logic      ser_out;
    logic      ser_frame;
    logic      word_done;
    ham_code_t enc_out;

    modport master (
        output data_in, data_valid,
        input  data_ready, ser_out, ser_frame, word_done, enc_out
    );

    modport slave (
        input  data_in, data_valid,
        output data_ready, ser_out, ser_frame, word_done, enc_out
    );
endinterface

`default_nettype wire

// File: rtl/ham_fifo.sv
// ============================================================================
// Module      : ham_fifo
// Description : Circular codeword buffer with wrap-bit read/write pointers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ham_fifo
    import ham_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic      clock,
    input  wire logic      reset_n,
    input  wire logic      push,
    input  wire logic      pop,
    input  wire ham_code_t wdata,
    output ham_code_t      rdata,
    output logic           full,
    output logic           empty
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    ham_code_t   r_mem [FIFO_DEPTH];
    logic        w_do_push;
    logic        w_do_pop;

    assign full      = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
    assign empty     = (r_wptr == r_rptr);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign rdata     = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= wdata;
    end
endmodule

`default_nettype wire

// File: rtl/ham_tx.sv
// ============================================================================
// Module      : ham_tx
// Description : Hamming (15,11) encoder, codeword FIFO and LSB-first serializer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ham_tx
    import ham_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic clock,
    input  wire logic reset_n,
    ham_tx_if.slave   bus
);
    ham_state_t r_state;
    ham_state_t w_state_nxt;
    ham_code_t  r_code;
    ham_code_t  w_code_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic       w_pop;
    logic       w_push;
    logic       w_full;
    logic       w_empty;
    ham_code_t  w_head;
    ham_code_t  w_enc;

    assign w_enc  = ham_encode(bus.data_in);
    assign w_push = bus.data_valid && bus.data_ready;

    ham_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (w_push),
        .pop     (w_pop),
        .wdata   (w_enc),
        .rdata   (w_head),
        .full    (w_full),
        .empty   (w_empty)
    );

    // r_code is both the shift source and the debug view of the codeword.
    assign bus.data_ready = reset_n && !w_full;
    assign bus.ser_frame  = (r_state == ST_SEND);
    assign bus.ser_out    = (r_state == ST_SEND) ? r_code[r_cnt] : 1'b0;
    assign bus.word_done  = (r_state == ST_SEND) && (r_cnt == CNT_LAST);
    assign bus.enc_out    = r_code;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_code  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_code  <= w_code_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_code_nxt  = r_code;
        w_cnt_nxt   = r_cnt;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_code_nxt  = w_head;
                    w_cnt_nxt   = CNT_FIRST;
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (r_cnt == CNT_LAST) begin
                    if (!w_empty) begin
                        w_pop      = 1'b1;
                        w_code_nxt = w_head;
                        w_cnt_nxt  = CNT_FIRST;
                    end else begin
                        w_code_nxt  = '0;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end
endmodule

`default_nettype wire

// File: tb/tb_ham_tx.sv
// ============================================================================
// Module      : tb_ham_tx
// Description : Directed/random bench for ham_tx against a positional Hamming model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ham_tx;
    import ham_pkg::*;

    localparam int DEPTH = 4;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    ham_tx_if bus();

    ham_tx #(.FIFO_DEPTH(DEPTH)) u_dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:1] got_q  [$];
    logic [15:1] encw_q [$];
    int          done_q [$];
    logic [10:0] exp_q  [$];

    logic [14:1] cur;
    int idx = 0;
    int run = 0;
    int last_run = 0;
    int frame_cnt = 0;

    // Deserializer: collects frame bits and records where word_done landed.
    always @(negedge clock) begin
        if (!reset_n) begin
            idx <= 0;
            run <= 0;
        end else if (bus.ser_frame) begin
            if (idx < 14) cur[idx+1] <= bus.ser_out;
            idx       <= idx + 1;
            run       <= run + 1;
            frame_cnt <= frame_cnt + 1;
            if (bus.word_done) begin
                got_q.push_back({bus.ser_out, cur});
                done_q.push_back(idx + 1);
                encw_q.push_back(bus.enc_out);
                idx <= 0;
            end
        end else begin
            if (run > 0) last_run <= run;
            run <= 0;
        end
    end

    function automatic logic [15:1] model_code(input logic [10:0] d);
        logic [15:1] c;
        logic        b;
        int          k;
        c = '0;
        k = 0;
        for (int pos = 1; pos <= 15; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                c[pos] = d[k];
                k++;
            end
        end
        for (int p = 1; p <= 8; p = p * 2) begin
            b = 1'b0;
            for (int pos = 1; pos <= 15; pos++)
                if (((pos & p) != 0) && (pos != p)) b = b ^ c[pos];
            c[p] = b;
        end
        return c;
    endfunction

    function automatic logic [15:1] model_fix(input logic [15:1] c);
        int s;
        s = 0;
        for (int pos = 1; pos <= 15; pos++)
            if (c[pos]) s = s ^ pos;
        if (s != 0) c[s] = ~c[s];
        return c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic push_word(input logic [10:0] d);
        int c;
        @(negedge clock);
        bus.data_valid = 1'b1;
        bus.data_in    = d;
        c = 0;
        while (!bus.data_ready && c < 200) begin
            @(negedge clock);
            c++;
        end
        if (bus.data_ready) begin
            @(posedge clock);
            exp_q.push_back(d);
        end else begin
            chk("push_ready_timeout", {31'd0, bus.data_ready}, 32'd1);
        end
    endtask

    task automatic drop_valid();
        @(negedge clock);
        bus.data_valid = 1'b0;
        bus.data_in    = 11'($urandom);
    endtask

    task automatic wait_words(input int n, input int budget);
        int c;
        c = 0;
        while (got_q.size() < n && c < budget) begin
            @(posedge clock);
            c++;
        end
        chk("word_count", got_q.size(), n);
    endtask

    task automatic drain(input string tag);
        logic [10:0] d;
        logic [15:1] g;
        logic [15:1] f;
        while (exp_q.size() > 0) begin
            if (got_q.size() == 0) begin
                chk({tag, "_missing"}, exp_q.size(), 0);
                exp_q.delete();
                break;
            end
            d = exp_q.pop_front();
            g = got_q.pop_front();
            chk({tag, "_code"}, g, model_code(d));
            chk({tag, "_done_pos"}, done_q.pop_front(), 15);
            chk({tag, "_enc_out"}, encw_q.pop_front(), model_code(d));
            chk({tag, "_pkg_enc"}, ham_encode(d), model_code(d));
            f = '0;
            f[$urandom_range(1, 15)] = 1'b1;
            chk({tag, "_fix"}, model_fix(g ^ f), model_code(d));
        end
    endtask

    initial begin
        logic [10:0] a;
        int acc;
        int low;
        int fc;

        bus.data_valid = 1'b0;
        bus.data_in    = '0;

        // Reset values
        repeat (3) @(negedge clock);
        chk("rst_ready", bus.data_ready, 0);
        chk("rst_frame", bus.ser_frame, 0);
        chk("rst_ser",   bus.ser_out, 0);
        chk("rst_done",  bus.word_done, 0);
        chk("rst_enc",   bus.enc_out, 0);
        reset_n = 1'b1;
        @(negedge clock);
        chk("rel_ready", bus.data_ready, 1);
        chk("rel_frame", bus.ser_frame, 0);

        // Single word 11'h001 with first-bit latency
        push_word(11'h001);
        drop_valid();
        chk("lat_idle_frame", bus.ser_frame, 0);
        @(negedge clock);
        chk("lat_frame", bus.ser_frame, 1);
        chk("lat_enc",   bus.enc_out, 15'h0007);
        chk("lat_bit1",  bus.ser_out, 1);
        wait_words(1, 100);
        chk("w001_lit", got_q[0], 15'h0007);
        drain("w001");
        repeat (3) @(posedge clock);

        // Back-to-back all-zero / all-one words: 30-cycle unbroken frame
        push_word(11'h000);
        push_word(11'h7FF);
        drop_valid();
        wait_words(2, 100);
        repeat (3) @(posedge clock);
        chk("bb_run", last_run, 30);
        chk("bb_w0", got_q[0], 15'h0000);
        chk("bb_w1", got_q[1], 15'h7FFF);
        drain("bb");

        // Capacity: serializer word + DEPTH queued
        acc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (!bus.data_ready) break;
            a = 11'($urandom);
            bus.data_valid = 1'b1;
            bus.data_in    = a;
            @(posedge clock);
            exp_q.push_back(a);
            acc++;
        end
        bus.data_valid = 1'b0;
        chk("cap_accepted", acc, DEPTH + 1);
        low = 1;
        while (low < 100) begin
            @(negedge clock);
            if (bus.data_ready) break;
            low++;
        end
        chk("cap_ready_low_cycles", low, 16 - DEPTH);
        wait_words(DEPTH + 1, 200);
        drain("cap");
        repeat (3) @(posedge clock);

        // Reset during bit 7 with two words queued
        a = 11'($urandom);
        push_word(a);
        push_word(11'($urandom));
        push_word(11'($urandom));
        drop_valid();
        repeat (5) @(negedge clock);
        chk("mid_frame", bus.ser_frame, 1);
        chk("mid_bit7", bus.ser_out, model_code(a)[7]);
        reset_n = 1'b0;
        @(negedge clock);
        chk("mid_rst_frame", bus.ser_frame, 0);
        chk("mid_rst_ser",   bus.ser_out, 0);
        chk("mid_rst_enc",   bus.enc_out, 0);
        chk("mid_rst_done",  bus.word_done, 0);
        reset_n = 1'b1;
        exp_q.delete();
        fc = frame_cnt;
        @(negedge clock);
        chk("mid_rel_ready", bus.data_ready, 1);
        repeat (50) @(posedge clock);
        chk("mid_no_frames", frame_cnt, fc);
        chk("mid_no_words", got_q.size(), 0);

        // Full data sweep with random idle gaps
        for (int d = 0; d < 2048; d++) begin
            push_word(11'(d));
            if ($urandom_range(0, 7) == 0) drop_valid();
        end
        drop_valid();
        wait_words(2048, 2048 * 16 + 500);
        drain("sweep");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

`default_nettype wire
